// File: rtl/ram_sdp_clr_if.sv
// Write/read/clear bundle for ram_sdp_clr.
// The master drives requests; the slave (the RAM) returns data and status.
interface ram_sdp_clr_if #(
  parameter int D_WIDTH    = 12,
  parameter int ADDR_WIDTH = 16
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [D_WIDTH-1:0]    data_inn;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  clear_req;
  logic                  parity_flip;
  logic [D_WIDTH-1:0]    data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  parity_err;

  modport master (
    output write_enable, write_address, data_inn,
    output read_enable, read_address,
    output clear_req, parity_flip,
    input  data_out, data_valid, busy, parity_err
  );

  modport slave (
    input  write_enable, write_address, data_inn,
    input  read_enable, read_address,
    input  clear_req, parity_flip,
    output data_out, data_valid, busy, parity_err
  );
endinterface

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM: 1/2-stage registered read, write-first bypass, clear sequencer.
// Define RAM_PARITY_EN to store and check an even-parity bit per word.
module ram_sdp_clr #(
  parameter int                 D_WIDTH      = 12,
  parameter int                 ADDR_WIDTH   = 16,
  parameter int                 READ_LATENCY = 1,
  parameter logic [D_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input logic          clk,
  input logic          rst,
  ram_sdp_clr_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [D_WIDTH-1:0]    word_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic  vld;
    logic  perr;
    word_t data;
  } rd_t;

  state_t state_q, state_d;
  addr_t  clr_addr_q, clr_addr_d;
  rd_t    s1_q, s1_d;
  word_t  mem [DEPTH];

  logic  in_clr;
  logic  mem_we;
  addr_t mem_wa;
  word_t mem_wd;
  logic  rd_fire;
  logic  bypass;
  word_t rd_word;
  logic  perr_rd;

  assign in_clr   = (state_q == CLEAR);
  assign bus.busy = in_clr;
  assign rd_fire  = ~in_clr & bus.read_enable;
  assign bypass   = bus.write_enable &
                    (bus.write_address == bus.read_address);

  // The sequencer owns the write port while clearing.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_addr_q;
    mem_wd = CLEAR_VALUE;
    unique case (1'b1)
      in_clr: mem_we = ~rst;
      default: begin
        mem_we = bus.write_enable & ~rst;
        mem_wa = bus.write_address;
        mem_wd = bus.data_inn;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    rd_word = bypass ? bus.data_inn : mem[bus.read_address];
  end

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic mem_wp;
  logic rd_par;

  assign mem_wp  = in_clr ? ^CLEAR_VALUE
                          : (^bus.data_inn ^ bus.parity_flip);
  assign rd_par  = bypass ? (^bus.data_inn ^ bus.parity_flip)
                          : par_mem[bus.read_address];
  assign perr_rd = (^rd_word) ^ rd_par;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_wa] <= mem_wp;
    end
  end
`else
  logic unused_flip;

  assign unused_flip = bus.parity_flip;
  assign perr_rd     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + addr_t'(1);
        if (&clr_addr_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Data holds between results so data_out keeps the last delivered word.
  always_comb begin
    s1_d      = s1_q;
    s1_d.vld  = rd_fire;
    s1_d.perr = rd_fire & perr_rd;
    if (rd_fire) begin
      s1_d.data = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      s1_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      s1_q       <= s1_d;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.data_out   = s1_q.data;
    assign bus.data_valid = s1_q.vld;
    assign bus.parity_err = s1_q.perr;
  end else if (READ_LATENCY == 2) begin : g_lat2
    rd_t s2_q, s2_d;

    always_comb begin
      s2_d      = s2_q;
      s2_d.vld  = s1_q.vld;
      s2_d.perr = s1_q.vld & s1_q.perr;
      if (s1_q.vld) begin
        s2_d.data = s1_q.data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_q <= '0;
      end else begin
        s2_q <= s2_d;
      end
    end

    assign bus.data_out   = s2_q.data;
    assign bus.data_valid = s2_q.vld;
    assign bus.parity_err = s2_q.perr;
  end else begin : g_bad_latency
    $error("ram_sdp_clr: READ_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: latency-1 and latency-2 instances share one stimulus stream
// and are checked against a behavioural model feeding per-instance expect queues.
module tb_ram_sdp_clr;

  localparam int          AW = 4;
  localparam int          DW = 12;
  localparam logic [11:0] CV = 12'hABC;
`ifdef RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re, creq, pflip;
  logic [3:0]  wa, ra;
  logic [11:0] din;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   vcnt1   = 0;
  int   vcnt2   = 0;
  bit   mon_en  = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  logic [11:0] m_mem [16];
  logic        m_par [16];
  logic        m_clr;
  logic [3:0]  m_ca;

  always #5 clk = ~clk;

  ram_sdp_clr_if #(.D_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  ram_sdp_clr_if #(.D_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  assign b1.write_enable  = we;
  assign b1.write_address = wa;
  assign b1.data_inn      = din;
  assign b1.read_enable   = re;
  assign b1.read_address  = ra;
  assign b1.clear_req     = creq;
  assign b1.parity_flip   = pflip;
  assign b2.write_enable  = we;
  assign b2.write_address = wa;
  assign b2.data_inn      = din;
  assign b2.read_enable   = re;
  assign b2.read_address  = ra;
  assign b2.clear_req     = creq;
  assign b2.parity_flip   = pflip;

  ram_sdp_clr #(
    .D_WIDTH(DW), .ADDR_WIDTH(AW),
    .READ_LATENCY(1), .CLEAR_VALUE(CV)
  ) u_lat1 (.clk(clk), .rst(rst), .bus(b1.slave));

  ram_sdp_clr #(
    .D_WIDTH(DW), .ADDR_WIDTH(AW),
    .READ_LATENCY(2), .CLEAR_VALUE(CV)
  ) u_lat2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // Reference model: sampled inputs at each rising edge.
  initial begin
    exp_t        e;
    logic [11:0] d;
    logic        st;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_clr = 1'b1;
        m_ca  = 4'h0;
        q1.delete();
        q2.delete();
      end else if (m_clr) begin
        m_mem[m_ca] = CV;
        m_par[m_ca] = ^CV;
        if (m_ca == 4'hF) m_clr = 1'b0;
        m_ca = m_ca + 4'h1;
      end else begin
        if (re) begin
          if (we && wa == ra) begin
            d  = din;
            st = (^din) ^ pflip;
          end else begin
            d  = m_mem[ra];
            st = m_par[ra];
          end
          e.data = d;
          e.perr = PAR_EN && ((^d) != st);
          e.due  = cyc;
          q1.push_back(e);
          e.due  = cyc + 1;
          q2.push_back(e);
        end
        if (we) begin
          m_mem[wa] = din;
          m_par[wa] = (^din) ^ pflip;
        end
        if (creq) begin
          m_clr = 1'b1;
          m_ca  = 4'h0;
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ev = (q1.size() != 0) && (q1[0].due == cyc);
        n_tests++;
        if (b1.data_valid !== ev) begin
          n_fail++;
          $display("FAIL lat1_valid cyc=%0d got=%b want=%b",
                   cyc, b1.data_valid, ev);
        end
        if (ev) begin
          n_tests++;
          if (b1.data_out !== q1[0].data ||
              b1.parity_err !== q1[0].perr) begin
            n_fail++;
            $display("FAIL lat1_data cyc=%0d got=%h/%b want=%h/%b",
                     cyc, b1.data_out, b1.parity_err,
                     q1[0].data, q1[0].perr);
          end
          void'(q1.pop_front());
        end
        ev = (q2.size() != 0) && (q2[0].due == cyc);
        n_tests++;
        if (b2.data_valid !== ev) begin
          n_fail++;
          $display("FAIL lat2_valid cyc=%0d got=%b want=%b",
                   cyc, b2.data_valid, ev);
        end
        if (ev) begin
          n_tests++;
          if (b2.data_out !== q2[0].data ||
              b2.parity_err !== q2[0].perr) begin
            n_fail++;
            $display("FAIL lat2_data cyc=%0d got=%h/%b want=%h/%b",
                     cyc, b2.data_out, b2.parity_err,
                     q2[0].data, q2[0].perr);
          end
          void'(q2.pop_front());
        end
        n_tests++;
        if (b1.busy !== m_clr || b2.busy !== m_clr) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b/%b want=%b",
                   cyc, b1.busy, b2.busy, m_clr);
        end
        if (b1.data_valid === 1'b1) vcnt1++;
        if (b2.data_valid === 1'b1) vcnt2++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic w, input logic [3:0] a_w,
                       input logic [11:0] d, input logic r,
                       input logic [3:0] a_r, input logic c,
                       input logic f);
    @(negedge clk);
    we    = w;
    wa    = a_w;
    din   = d;
    re    = r;
    ra    = a_r;
    creq  = c;
    pflip = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_clear(output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 100 && (b1.busy || b2.busy); i++) begin
      if (b1.busy) c1++;
      if (b2.busy) c2++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int c1, c2, v1, v2;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(c1, c2);
    n_tests++;
    if (c1 != 16 || c2 != 16) begin
      n_fail++;
      $display("FAIL reset_clear_len got=%0d/%0d want=16", c1, c2);
    end
    v1 = vcnt1;
    v2 = vcnt2;
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 4'(i), 0, 0);
    idle(3);
    n_tests++;
    if (vcnt1 - v1 != 16 || vcnt2 - v2 != 16) begin
      n_fail++;
      $display("FAIL reset_read_pulses got=%0d/%0d want=16",
               vcnt1 - v1, vcnt2 - v2);
    end
  endtask

  task automatic test_latency;
    drive(1, 5, 12'h123, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (b1.data_valid !== 1'b1 || b1.data_out !== 12'h123 ||
        b2.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_1 got=%b/%h lat2_vld=%b want=1/123 0",
               b1.data_valid, b1.data_out, b2.data_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (b2.data_valid !== 1'b1 || b2.data_out !== 12'h123 ||
        b1.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_2 got=%b/%h lat1_vld=%b want=1/123 0",
               b2.data_valid, b2.data_out, b1.data_valid);
    end
    idle(3);
  endtask

  task automatic test_collision;
    drive(1, 3, 12'h000, 0, 0, 0, 0);
    drive(1, 3, 12'h7FF, 1, 3, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    n_tests++;
    if (b1.data_valid !== 1'b1 || b1.data_out !== 12'h7FF) begin
      n_fail++;
      $display("FAIL collision_bypass got=%b/%h want=1/7ff",
               b1.data_valid, b1.data_out);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (b1.data_out !== 12'h7FF || b2.data_out !== 12'h7FF) begin
      n_fail++;
      $display("FAIL collision_after got=%h/%h want=7ff",
               b1.data_out, b2.data_out);
    end
    idle(3);
  endtask

  task automatic test_clear_mid;
    int c1, c2;
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 12'(i), 0, 0, 0, 0);
    drive(0, 0, 0, 1, 9, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (b1.data_valid !== 1'b1 || b1.data_out !== 12'h009) begin
      n_fail++;
      $display("FAIL clear_req_read got=%b/%h want=1/009",
               b1.data_valid, b1.data_out);
    end
    for (int i = 0; i < 15; i++)
      drive(1'($urandom_range(1)), 4'($urandom), 12'($urandom),
            1'($urandom_range(1)), 4'($urandom),
            1'($urandom_range(1)), 1'($urandom_range(1)));
    drive(0, 0, 0, 0, 0, 0, 0);
    wait_clear(c1, c2);
    n_tests++;
    if (c1 != 0 || c2 != 0) begin
      n_fail++;
      $display("FAIL clear_req_len extra=%0d/%0d want=0", c1, c2);
    end
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 4'(i), 0, 0);
    idle(3);
  endtask

  task automatic test_reset_mid;
    int c1, c2;
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (b1.busy !== 1'b1 || b2.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy got=%b/%b want=1", b1.busy, b2.busy);
    end
    rst = 1'b0;
    wait_clear(c1, c2);
    n_tests++;
    if (c1 != 16 || c2 != 16) begin
      n_fail++;
      $display("FAIL reset_mid_len got=%0d/%0d want=16", c1, c2);
    end
  endtask

  task automatic test_parity;
    drive(1, 2, 12'h001, 0, 0, 0, 1);
    drive(1, 4, 12'h003, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 1, 4, 0, 0);
    n_tests++;
    if (b1.data_valid !== 1'b1 || b1.parity_err !== PAR_EN) begin
      n_fail++;
      $display("FAIL parity_flip got=%b/%b want=1/%b",
               b1.data_valid, b1.parity_err, PAR_EN);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (b1.data_valid !== 1'b1 || b1.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_ok got=%b/%b want=1/0",
               b1.data_valid, b1.parity_err);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    int v1, v2;
    v1 = vcnt1;
    v2 = vcnt2;
    for (int i = 0; i < 16; i++)
      drive(1, 4'(i), 12'(i * 37 + 5), 1, 4'(15 - i), 0, 0);
    idle(3);
    n_tests++;
    if (vcnt1 - v1 != 16 || vcnt2 - v2 != 16) begin
      n_fail++;
      $display("FAIL b2b_pulses got=%0d/%0d want=16",
               vcnt1 - v1, vcnt2 - v2);
    end
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    wa    = '0;
    din   = '0;
    re    = 1'b0;
    ra    = '0;
    creq  = 1'b0;
    pflip = 1'b0;
    m_clr = 1'b1;
    m_ca  = '0;
    test_reset();
    test_latency();
    test_collision();
    test_clear_mid();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    idle(4);
    n_tests++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results got=%0d/%0d want=0",
               q1.size(), q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Successor to the combinational-read pixel/tile RAM. Adds a registered read pipeline of 1 or 2 stages with a valid strobe.
- Write-first collision bypass.
- Hardware clear sequencer that fills the whole array with a constant after reset or on request. Used for framebuffer and tile memories in the video path.

Parameters:
- D_WIDTH, 12, data word width in bits (1..64).
- ADDR_WIDTH, 16, address width; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, edges from read request to data_out; legal values 1 or 2 (other values: elaboration error).
- CLEAR_VALUE, 0, D_WIDTH-bit word written to every location by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- write_enable  in  1  write request, sampled each edge.
- write_address  in  ADDR_WIDTH  write location.
- data_inn  in  D_WIDTH  write data.
- read_enable  in  1  read request, sampled each edge.
- read_address  in  ADDR_WIDTH  read location.
- clear_req  in  1  single-cycle request to re-clear the whole array.
- parity_flip  in  1  test hook: store inverted parity on this write (RAM_PARITY_EN only).
- data_out  out  D_WIDTH  read data, registered.
- data_valid  out  1  one-cycle strobe, high while data_out holds the result of a request.
- busy  out  1  clear sequencer active; array not accessible.
- parity_err  out  1  parity mismatch on the returned word, aligned with data_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=CLEAR, clr_addr<=0, data_out<=0, data_valid<=0, parity_err<=0, busy<=1.
  - All read pipeline stages are flushed (valid bits cleared).
  - The array is not written while rst=1.
- FSM states:
  - IDLE: normal operation, busy=0.
  - CLEAR: each edge writes CLEAR_VALUE to mem[clr_addr] and increments clr_addr. clr_addr is an ADDR_WIDTH-bit counter.
- Transitions:
  - CLEAR to IDLE: on the edge that writes the last address (all ones). busy falls after that edge.
  - Clear duration: busy=1 for exactly 2**ADDR_WIDTH edges after the first edge with rst=0.
  - IDLE to CLEAR: on an edge with clear_req=1, clr_addr<=0. busy rises after that edge.
  - Any user write or read sampled on that same edge is still performed normally.
- During CLEAR:
  - write_enable, read_enable and clear_req are ignored; no data_valid is generated.
  - Reads already in the pipeline complete normally. They return data read before the clear began.
- Reset mid-clear restarts the clear from address 0.
- Write (IDLE): on the edge, if write_enable=1 then mem[write_address]<=data_inn.
- Read (IDLE):
  - The array is sampled at the request edge N.
  - READ_LATENCY=1: data_out and data_valid update at edge N; data_valid is high for the cycle after N.
  - READ_LATENCY=2: one extra output register; data_valid is high for the cycle after N+1.
- Collision: if read_enable and write_enable are both high with equal addresses on the same edge, the read returns data_inn (write-first).
  - A write at a later edge does not alter a read already in the pipeline.
- Throughput: one read and one write per cycle, fully pipelined. Back-to-back reads give consecutive data_valid pulses.
- data_out holds its last value when no result is delivered; data_valid=0 in that case.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit: XOR of the data, inverted if parity_flip=1 on the write.
  - The clear sequencer stores the correct parity of CLEAR_VALUE.
  - On each returned word, parity is recomputed. parity_err=1 with data_valid if it mismatches the stored bit, else 0.
  - A write-first bypass returns parity computed from data_inn, honouring parity_flip.
- Not defined: no parity storage, parity_flip ignored, parity_err tied 0. Port list is identical in both builds.

Test Plan (ADDR_WIDTH=4, D_WIDTH=12 unless stated):
- Post-reset clear, CLEAR_VALUE=12'hABC: pulse rst for 2 cycles, then count cycles with busy=1.
  - Required: exactly 16 cycles, then busy=0.
  - Reading addresses 0..15 returns 12'hABC with 16 data_valid pulses.
- Latency, READ_LATENCY=1 and 2: write 12'h123 to addr 5, then read addr 5.
  - Required: data_out=12'h123 with data_valid after 1 or 2 edges respectively.
  - data_valid is never asserted for idle cycles.
- Collision: at one edge, write 12'h7FF to addr 3 and read addr 3 (old content 12'h000).
  - Required: returned data is 12'h7FF.
  - A following read of addr 3 also returns 12'h7FF.
- Clear request mid-stream:
  - Fill addrs 0..15 with their index, issue clear_req together with a read of addr 9.
  - Required: that read returns 12'h009.
  - Reads and writes during the 16 busy cycles are ignored (no data_valid, no write).
  - Reads afterwards return CLEAR_VALUE.
- Reset mid-clear: assert rst at busy cycle 7.
  - Required: busy stays 1, and 16 full clear cycles follow the release of rst.
- RAM_PARITY_EN: write 12'h001 to addr 2 with parity_flip=1, and 12'h003 to addr 4 normally; then read both.
  - Required: parity_err=1 with addr 2's data_valid, 0 with addr 4's.
  - Without the macro: parity_err stays 0.
